// File: rtl/eth_rx_capture.sv
// Captures one Ethernet frame from the MAC receive FIFO stream and replays it to a sequential reader.
// Optional statistics counters are built only when ETH_RX_STATS_EN is defined.
module eth_rx_capture #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] ff_rx_data_i,
    input  logic        ff_rx_dval_i,
    input  logic        ff_rx_sop_i,
    input  logic        ff_rx_eop_i,
    input  logic [1:0]  ff_rx_mod_i,
    input  logic        ff_rx_err_i,
    output logic        ff_rx_rdy_o,
    input  logic        rd_en_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        rd_last_o,
    output logic        frame_done_o,
    output logic [15:0] frame_len_o,
    output logic [15:0] frame_count_o,
    output logic [15:0] drop_count_o
);

    typedef enum logic [1:0] {StIdle, StCapture, StDrop, StDrain} state_e;

    localparam logic [ADDR_W:0] Full = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] One  = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]   nwords_q, nwords_d;
    logic [15:0]       len_q, len_d;
    logic              done_q, done_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;

    logic [31:0]       mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              xfer;
    logic              start;
    logic              drop_inc;
    logic              frame_inc;

    // Reset forces not-ready even though IDLE alone would follow en.
    always_comb begin
        if (rst_i) begin
            ff_rx_rdy_o = 1'b0;
        end else begin
            unique case (state_q)
                StIdle:             ff_rx_rdy_o = en_i;
                StCapture, StDrop:  ff_rx_rdy_o = 1'b1;
                default:            ff_rx_rdy_o = 1'b0;
            endcase
        end
    end

    assign xfer = ff_rx_dval_i & ff_rx_rdy_o;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        nwords_d   = nwords_q;
        len_d      = len_q;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        we         = 1'b0;
        waddr      = wptr_q[ADDR_W-1:0];
        start      = 1'b0;
        drop_inc   = 1'b0;
        frame_inc  = 1'b0;

        unique case (state_q)
            StIdle, StDrop: begin
                if (xfer) begin
                    if (ff_rx_sop_i) begin
                        start = 1'b1;
                    end else if (state_q == StDrop && ff_rx_eop_i) begin
                        state_d = StIdle;
                    end
                end
            end
            StCapture: begin
                if (xfer) begin
                    if (ff_rx_sop_i) begin
                        drop_inc = 1'b1;
                        start    = 1'b1;
                    end else if (wptr_q == Full) begin
                        drop_inc = 1'b1;
                        state_d  = ff_rx_eop_i ? StIdle : StDrop;
                    end else begin
                        we     = 1'b1;
                        wptr_d = wptr_q + One;
                    end
                end
            end
            default: begin
                if (rd_en_i) begin
                    rd_data_d  = mem[rptr_q[ADDR_W-1:0]];
                    rd_valid_d = 1'b1;
                    if (rptr_q == nwords_q - One) begin
                        rd_last_d = 1'b1;
                        rptr_d    = '0;
                        state_d   = StIdle;
                    end else begin
                        rptr_d = rptr_q + One;
                    end
                end
            end
        endcase

        if (start) begin
            we      = 1'b1;
            waddr   = '0;
            wptr_d  = One;
            state_d = StCapture;
        end

        // wptr_d already holds the word count including the eop word.
        if (we && ff_rx_eop_i) begin
            if (ff_rx_err_i) begin
                drop_inc = 1'b1;
                state_d  = StIdle;
            end else begin
                len_d     = (16'(wptr_d) << 2) - 16'(ff_rx_mod_i);
                done_d    = 1'b1;
                frame_inc = 1'b1;
                nwords_d  = wptr_d;
                rptr_d    = '0;
                state_d   = StDrain;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            nwords_q   <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            nwords_q   <= nwords_d;
            len_q      <= len_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= ff_rx_data_i;
        end
    end

    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_last_o    = rd_last_q;
    assign frame_done_o = done_q;
    assign frame_len_o  = len_q;

`ifdef ETH_RX_STATS_EN
    logic [15:0] frame_cnt_q, drop_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (drop_inc)  drop_cnt_q  <= drop_cnt_q + 16'd1;
        end
    end

    assign frame_count_o = frame_cnt_q;
    assign drop_count_o  = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats  = frame_inc | drop_inc;
    assign frame_count_o = '0;
    assign drop_count_o  = '0;
`endif

endmodule
